// File: rtl/div_issue_ctrl_if.sv
// div_issue_ctrl_if: bundles the pipeline request/response signals and the
// divider start/ready handshake of the EX-stage divide sequencer.
//   Pipeline side : req_valid, req_op, req_s1, req_s2, flush  -> controller
//                   stall, rsp_valid, rsp_data                <- controller
//   Divider side  : div_start, div_s1, div_s2                 <- controller
//                   div_ready, div_quotient, div_remainder    -> controller
// master = the sequencer itself, slave = the pipeline plus divider around it.
interface div_issue_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_s1;
  logic [XLEN-1:0] req_s2;
  logic            flush;
  logic            stall;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;
  logic            div_start;
  logic [XLEN:0]   div_s1;
  logic [XLEN:0]   div_s2;
  logic            div_ready;
  logic [XLEN:0]   div_quotient;
  logic [XLEN:0]   div_remainder;

  modport master (
    input  req_valid, req_op, req_s1, req_s2, flush,
    input  div_ready, div_quotient, div_remainder,
    output stall, rsp_valid, rsp_data,
    output div_start, div_s1, div_s2
  );

  modport slave (
    output req_valid, req_op, req_s1, req_s2, flush,
    output div_ready, div_quotient, div_remainder,
    input  stall, rsp_valid, rsp_data,
    input  div_start, div_s1, div_s2
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: initiator-side sequencer for the RV32M divide path.
// Accepts DIV/DIVU/REM/REMU from EX, extends and registers the operands,
// pulses div_start to the multi-cycle XLEN+1-bit divider and stalls the
// pipeline until div_ready, then returns the selected result with a
// one-cycle rsp_valid. Divide-by-zero, signed overflow and repeats of the
// last divided operand pair (single-entry result cache) complete without
// the divider.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - div_issue_ctrl_if.master (pipeline request/response + divider)
module div_issue_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  div_issue_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_e;

  state_e          state_q, state_d;

  logic            dreq;
  logic            req_signed;
  logic            div_by_zero;
  logic            overflow;
  logic            cache_hit;
  logic            fast_path;
  logic [XLEN-1:0] s_min;
  logic [XLEN:0]   ext_s1, ext_s2;
  logic [XLEN-1:0] fast_quo, fast_rem, fast_result, div_result;

  logic            issue, fast_take, slow_take, cache_wr;
  logic            stall_c, rsp_valid_c, div_start_c;

  logic [XLEN:0]   div_s1_q, div_s2_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] rsp_data_q;

  logic            cache_vld_q;
  logic            cache_sgn_q;
  logic [XLEN-1:0] cache_s1_q, cache_s2_q;
  logic [XLEN-1:0] cache_quo_q, cache_rem_q;

  logic            unused_msbs;

  assign s_min = {1'b1, {(XLEN-1){1'b0}}};

  // op[2] marks the divide group; op[0] clear means signed (DIV/REM).
  assign dreq       = bus.req_valid & bus.req_op[2] & ~bus.flush;
  assign req_signed = ~bus.req_op[0];

  assign ext_s1 = {req_signed & bus.req_s1[XLEN-1], bus.req_s1};
  assign ext_s2 = {req_signed & bus.req_s2[XLEN-1], bus.req_s2};

  assign div_by_zero = (bus.req_s2 == '0);
  assign overflow    = req_signed & (bus.req_s1 == s_min) & (bus.req_s2 == '1);
  assign cache_hit   = cache_vld_q
                     & (cache_s1_q == bus.req_s1)
                     & (cache_s2_q == bus.req_s2)
                     & (cache_sgn_q == req_signed);
  assign fast_path   = div_by_zero | overflow | cache_hit;

  // Architectural special cases take priority over the cache; the cache
  // never holds a special-case pair, so the order only matters for clarity.
  always_comb begin
    fast_quo = cache_quo_q;
    fast_rem = cache_rem_q;
    if (div_by_zero) begin
      fast_quo = '1;
      fast_rem = bus.req_s1;
    end else if (overflow) begin
      fast_quo = s_min;
      fast_rem = '0;
    end
  end

  assign fast_result = bus.req_op[1] ? fast_rem : fast_quo;
  assign div_result  = op_q[1] ? bus.div_remainder[XLEN-1:0]
                               : bus.div_quotient[XLEN-1:0];

  // The divider MSBs only exist for the extended arithmetic.
  assign unused_msbs = ^{bus.div_quotient[XLEN], bus.div_remainder[XLEN]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    fast_take   = 1'b0;
    slow_take   = 1'b0;
    cache_wr    = 1'b0;
    rsp_valid_c = 1'b0;
    div_start_c = 1'b0;
    stall_c     = dreq & (state_q != S_DONE);

    unique case (state_q)
      S_IDLE: begin
        if (dreq) begin
          if (fast_path) begin
            fast_take = 1'b1;
            state_d   = S_DONE;
          end else begin
            issue   = 1'b1;
            state_d = S_START;
          end
        end
      end
      S_START: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          div_start_c = 1'b1;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // A flush coinciding with div_ready has nothing left to drain:
        // keep the result in the cache and return straight to IDLE.
        if (bus.div_ready) begin
          cache_wr = 1'b1;
          if (bus.flush) begin
            state_d = S_IDLE;
          end else begin
            slow_take = 1'b1;
            state_d   = S_DONE;
          end
        end else if (bus.flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        rsp_valid_c = ~bus.flush;
        state_d     = S_IDLE;
      end
      S_DRAIN: begin
        if (bus.div_ready) begin
          cache_wr = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_s1_q    <= '0;
      div_s2_q    <= '0;
      op_q        <= '0;
      rsp_data_q  <= '0;
      cache_vld_q <= 1'b0;
      cache_sgn_q <= 1'b0;
      cache_s1_q  <= '0;
      cache_s2_q  <= '0;
      cache_quo_q <= '0;
      cache_rem_q <= '0;
    end else begin
      if (issue) begin
        div_s1_q <= ext_s1;
        div_s2_q <= ext_s2;
        op_q     <= bus.req_op[1:0];
      end
      if (fast_take) begin
        rsp_data_q <= fast_result;
      end else if (slow_take) begin
        rsp_data_q <= div_result;
      end
      // Cache key comes from the registered operands, which stay stable
      // from issue until the divider answers, including through DRAIN.
      if (cache_wr) begin
        cache_vld_q <= 1'b1;
        cache_sgn_q <= ~op_q[0];
        cache_s1_q  <= div_s1_q[XLEN-1:0];
        cache_s2_q  <= div_s2_q[XLEN-1:0];
        cache_quo_q <= bus.div_quotient[XLEN-1:0];
        cache_rem_q <= bus.div_remainder[XLEN-1:0];
      end
    end
  end

  // Outputs are held at zero for the whole time reset is asserted.
  assign bus.stall     = ~rst & stall_c;
  assign bus.rsp_valid = ~rst & rsp_valid_c;
  assign bus.div_start = ~rst & div_start_c;
  assign bus.rsp_data  = rst ? '0 : rsp_data_q;
  assign bus.div_s1    = rst ? '0 : div_s1_q;
  assign bus.div_s2    = rst ? '0 : div_s2_q;

endmodule
